// File: rtl/blck_sched_pkg.sv
// rtl/blck_sched_pkg.sv - state and phase encodings for the block sequencing controller
package blck_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_FILL = 3'd2,
    ST_PRIM = 3'd3,
    ST_TAG  = 3'd4,
    ST_FIN  = 3'd5
  } state_e;

  localparam logic [1:0] PH_AD   = 2'd0;
  localparam logic [1:0] PH_MSG  = 2'd1;
  localparam logic [1:0] PH_TAG  = 2'd2;
  localparam logic [1:0] PH_NONE = 2'd3;

endpackage

// File: rtl/blck_sched_cntrl_flag_core.sv
// rtl/blck_sched_cntrl_flag_core.sv - set/clear flag holding the last-block indication
module flag_core (
  input  logic clk,
  input  logic rst,
  input  logic set_i,
  input  logic syn_unset_i,
  output logic flag_o
);

  logic flag_q;
  logic flag_d;

  // Clear wins over set so an abort or phase change never leaves a stale flag.
  always_comb begin
    flag_d = flag_q;
    if (syn_unset_i) begin
      flag_d = 1'b0;
    end else if (set_i) begin
      flag_d = 1'b1;
    end
  end

  // Flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/blck_sched_cntrl.sv
// rtl/blck_sched_cntrl.sv - AD/MSG/TAG block sequencer for builder and primitive; optional abort via SCHED_ABORT_EN
module blck_sched_cntrl
  import blck_sched_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ad_empty,
  input  logic             msg_empty,
  output logic             bb_set_ready,
  input  logic             bb_ready,
  input  logic             bb_blck_rdy,
  input  logic             din_valid,
  input  logic             din_eot,
  output logic             prim_start,
  input  logic             prim_done,
  output logic [1:0]       phase,
  output logic             last_blck,
  output logic [CNT_W-1:0] blck_cnt,
  output logic             busy,
`ifdef SCHED_ABORT_EN
  input  logic             abort,
`endif
  output logic             done
);

  state_e           state_q, state_d;
  logic [1:0]       phase_q, phase_d;      // data phase (AD or MSG) while in ARM/FILL/PRIM
  logic             msg_empty_q, msg_empty_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;      // high on the entry cycle of PRIM/TAG
  logic             flag_set, flag_unset;
  logic             prim_ack;

  // A completion in the launch cycle belongs to no launch of ours, so it is masked.
  assign prim_ack = prim_done & ~first_q;

  // Next-state logic: phase walk AD -> MSG -> TAG with one launch per block.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    msg_empty_d = msg_empty_q;
    cnt_d       = cnt_q;
    first_d     = 1'b0;
    flag_set    = 1'b0;
    flag_unset  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          msg_empty_d = msg_empty;
          cnt_d       = '0;
          flag_unset  = 1'b1;
          if (!ad_empty) begin
            phase_d = PH_AD;
            state_d = ST_ARM;
          end else if (!msg_empty) begin
            phase_d = PH_MSG;
            state_d = ST_ARM;
          end else begin
            state_d = ST_TAG;
            first_d = 1'b1;
          end
        end
      end
      ST_ARM: state_d = ST_FILL;
      ST_FILL: begin
        flag_set = bb_ready & din_valid & din_eot;
        if (bb_blck_rdy) begin
          state_d = ST_PRIM;
          first_d = 1'b1;
        end
      end
      ST_PRIM: begin
        if (prim_ack) begin
          cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
          if (!last_blck) begin
            state_d = ST_ARM;
          end else begin
            flag_unset = 1'b1;
            if (phase_q == PH_AD && !msg_empty_q) begin
              phase_d = PH_MSG;
              state_d = ST_ARM;
            end else begin
              state_d = ST_TAG;
              first_d = 1'b1;
            end
          end
        end
      end
      ST_TAG: begin
        if (prim_ack) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
`ifdef SCHED_ABORT_EN
    if (abort) begin
      state_d    = ST_IDLE;
      phase_d    = phase_q;
      cnt_d      = cnt_q;
      first_d    = 1'b0;
      flag_set   = 1'b0;
      flag_unset = 1'b1;
    end
`endif
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      phase_q     <= PH_AD;
      msg_empty_q <= 1'b0;
      cnt_q       <= '0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      msg_empty_q <= msg_empty_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
    end
  end

  flag_core u_last_flag (
    .clk         (clk),
    .rst         (rst),
    .set_i       (flag_set),
    .syn_unset_i (flag_unset),
    .flag_o      (last_blck)
  );

  // Outputs are decoded from registered state only.
  always_comb begin
    phase = phase_q;
    case (state_q)
      ST_IDLE, ST_FIN: phase = PH_NONE;
      ST_TAG:          phase = PH_TAG;
      default:         phase = phase_q;
    endcase
  end

  assign bb_set_ready = (state_q == ST_ARM);
  assign prim_start   = first_q;
  assign done         = (state_q == ST_FIN);
  assign busy         = (state_q != ST_IDLE);
  assign blck_cnt     = cnt_q;

endmodule

// File: tb/tb_blck_sched_cntrl.sv
// tb/tb_blck_sched_cntrl.sv - directed self-checking bench for blck_sched_cntrl
module tb_blck_sched_cntrl;

  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, ad_empty = 1'b0, msg_empty = 1'b0;
  logic bb_ready = 1'b0, bb_blck_rdy = 1'b0, din_valid = 1'b0, din_eot = 1'b0;
  logic prim_done = 1'b0;
`ifdef SCHED_ABORT_EN
  logic abort = 1'b0;
`endif
  logic bb_set_ready, prim_start, last_blck, busy, done;
  logic [1:0] phase;
  logic [CNT_W-1:0] blck_cnt;

  int errors = 0;
  int checks = 0;

  int n_set_ready = 0;
  int n_done = 0;
  int n_ph0 = 0;
  logic [1:0] ph_log[$];

  blck_sched_cntrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ad_empty     (ad_empty),
    .msg_empty    (msg_empty),
    .bb_set_ready (bb_set_ready),
    .bb_ready     (bb_ready),
    .bb_blck_rdy  (bb_blck_rdy),
    .din_valid    (din_valid),
    .din_eot      (din_eot),
    .prim_start   (prim_start),
    .prim_done    (prim_done),
    .phase        (phase),
    .last_blck    (last_blck),
    .blck_cnt     (blck_cnt),
    .busy         (busy),
`ifdef SCHED_ABORT_EN
    .abort        (abort),
`endif
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      if (bb_set_ready) n_set_ready++;
      if (done) n_done++;
      if (busy && phase == 2'd0) n_ph0++;
      if (prim_start) ph_log.push_back(phase);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_block(input logic eot);
    bb_ready = 1'b1; din_valid = 1'b1; din_eot = eot;
    tick();
    bb_ready = 1'b0; din_valid = 1'b0; din_eot = 1'b0; bb_blck_rdy = 1'b1;
    tick();
    bb_blck_rdy = 1'b0;
  endtask

  task automatic finish_prim();
    repeat (5) tick();
    prim_done = 1'b1;
    tick();
    prim_done = 1'b0;
  endtask

  task automatic op_start(input logic ade, input logic mse);
    start = 1'b1; ad_empty = ade; msg_empty = mse;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (phase !== 2'd3) begin errors++; $display("FAIL reset_phase: got %0d expected 3", phase); end
    checks++; if (blck_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", blck_cnt); end
    checks++; if ({bb_set_ready, prim_start, last_blck, done} !== 4'b0) begin
      errors++; $display("FAIL reset_pulses: got %b expected 0000", {bb_set_ready, prim_start, last_blck, done}); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_ad2_msg1();
    int sr0, dn0, lb;
    sr0 = n_set_ready; dn0 = n_done; lb = ph_log.size();
    op_start(1'b0, 1'b0);
    checks++; if (bb_set_ready !== 1'b1) begin errors++; $display("FAIL t1_arm: got %0b expected 1", bb_set_ready); end
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL t1_phase_ad: got %0d expected 0", phase); end
    tick();
    fill_block(1'b0);
    checks++; if (prim_start !== 1'b1) begin errors++; $display("FAIL t1_prim1: got %0b expected 1", prim_start); end
    finish_prim();
    checks++; if (bb_set_ready !== 1'b1) begin errors++; $display("FAIL t1_rearm: got %0b expected 1", bb_set_ready); end
    checks++; if (blck_cnt !== 2'd1) begin errors++; $display("FAIL t1_cnt1: got %0d expected 1", blck_cnt); end
    tick();
    fill_block(1'b1);
    checks++; if (last_blck !== 1'b1) begin errors++; $display("FAIL t1_last: got %0b expected 1", last_blck); end
    finish_prim();
    checks++; if (phase !== 2'd1) begin errors++; $display("FAIL t1_phase_msg: got %0d expected 1", phase); end
    checks++; if (last_blck !== 1'b0) begin errors++; $display("FAIL t1_last_clr: got %0b expected 0", last_blck); end
    tick();
    fill_block(1'b1);
    finish_prim();
    checks++; if (prim_start !== 1'b1 || phase !== 2'd2) begin
      errors++; $display("FAIL t1_tag: got prim_start=%0b phase=%0d expected 1/2", prim_start, phase); end
    finish_prim();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t1_done: got %0b expected 1", done); end
    checks++; if (blck_cnt !== 2'd3) begin errors++; $display("FAIL t1_cnt_done: got %0d expected 3", blck_cnt); end
    checks++; if (phase !== 2'd3) begin errors++; $display("FAIL t1_phase_fin: got %0d expected 3", phase); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL t1_idle: got done=%0b busy=%0b expected 0/0", done, busy); end
    checks++; if (n_set_ready - sr0 != 3) begin errors++; $display("FAIL t1_setready_count: got %0d expected 3", n_set_ready - sr0); end
    checks++; if (n_done - dn0 != 1) begin errors++; $display("FAIL t1_done_count: got %0d expected 1", n_done - dn0); end
    checks++; if (ph_log.size() - lb != 4) begin
      errors++; $display("FAIL t1_phase_seq_len: got %0d expected 4", ph_log.size() - lb);
    end else if (ph_log[lb] !== 2'd0 || ph_log[lb+1] !== 2'd0 || ph_log[lb+2] !== 2'd1 || ph_log[lb+3] !== 2'd2) begin
      errors++; $display("FAIL t1_phase_seq: got %0d,%0d,%0d,%0d expected 0,0,1,2", ph_log[lb], ph_log[lb+1], ph_log[lb+2], ph_log[lb+3]);
    end
  endtask

  task automatic test_both_empty();
    int sr0;
    sr0 = n_set_ready;
    op_start(1'b1, 1'b1);
    checks++; if (prim_start !== 1'b1 || phase !== 2'd2) begin
      errors++; $display("FAIL t2_tag: got prim_start=%0b phase=%0d expected 1/2", prim_start, phase); end
    checks++; if (blck_cnt !== 2'd0) begin errors++; $display("FAIL t2_cnt: got %0d expected 0", blck_cnt); end
    finish_prim();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t2_done: got %0b expected 1", done); end
    tick();
    checks++; if (n_set_ready != sr0) begin errors++; $display("FAIL t2_no_setready: got %0d expected 0", n_set_ready - sr0); end
  endtask

  task automatic test_msg_only();
    int p0;
    p0 = n_ph0;
    op_start(1'b1, 1'b0);
    checks++; if (phase !== 2'd1) begin errors++; $display("FAIL t3_phase: got %0d expected 1", phase); end
    tick();
    fill_block(1'b1);
    finish_prim();
    checks++; if (prim_start !== 1'b1 || phase !== 2'd2) begin
      errors++; $display("FAIL t3_tag: got prim_start=%0b phase=%0d expected 1/2", prim_start, phase); end
    finish_prim();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t3_done: got %0b expected 1", done); end
    tick();
    checks++; if (n_ph0 != p0) begin errors++; $display("FAIL t3_no_ad: got %0d cycles in phase 0 expected 0", n_ph0 - p0); end
  endtask

  task automatic test_blck_rdy_in_arm();
    bb_blck_rdy = 1'b1;
    op_start(1'b0, 1'b1);
    checks++; if (bb_set_ready !== 1'b1) begin errors++; $display("FAIL t4_arm: got %0b expected 1", bb_set_ready); end
    tick();
    bb_blck_rdy = 1'b0;
    checks++; if (prim_start !== 1'b0) begin errors++; $display("FAIL t4_early_prim: got %0b expected 0", prim_start); end
    tick();
    checks++; if (prim_start !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL t4_still_fill: got prim_start=%0b busy=%0b expected 0/1", prim_start, busy); end
    fill_block(1'b1);
    checks++; if (prim_start !== 1'b1) begin errors++; $display("FAIL t4_prim: got %0b expected 1", prim_start); end
    finish_prim();
    finish_prim();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t4_done: got %0b expected 1", done); end
    tick();
  endtask

  task automatic test_ignored_inputs();
    op_start(1'b0, 1'b1);
    tick();
    fill_block(1'b1);
    prim_done = 1'b1; start = 1'b1;
    tick();
    prim_done = 1'b0;
    checks++; if (blck_cnt !== 2'd0 || busy !== 1'b1 || bb_set_ready !== 1'b0) begin
      errors++; $display("FAIL t5_entry_done: got cnt=%0d busy=%0b set_ready=%0b expected 0/1/0", blck_cnt, busy, bb_set_ready); end
    tick();
    start = 1'b0;
    checks++; if (prim_start !== 1'b0 || phase !== 2'd0) begin
      errors++; $display("FAIL t5_start_ignored: got prim_start=%0b phase=%0d expected 0/0", prim_start, phase); end
    finish_prim();
    checks++; if (prim_start !== 1'b1 || phase !== 2'd2 || blck_cnt !== 2'd1) begin
      errors++; $display("FAIL t5_tag: got prim_start=%0b phase=%0d cnt=%0d expected 1/2/1", prim_start, phase, blck_cnt); end
    prim_done = 1'b1;
    tick();
    prim_done = 1'b0;
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL t5_tag_entry_done: got done=%0b busy=%0b expected 0/1", done, busy); end
    finish_prim();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t5_done: got %0b expected 1", done); end
    tick();
  endtask

  task automatic test_saturation();
    op_start(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      fill_block(i == 3);
      finish_prim();
    end
    checks++; if (phase !== 2'd2 || blck_cnt !== 2'd3) begin
      errors++; $display("FAIL t6_saturate: got phase=%0d cnt=%0d expected 2/3", phase, blck_cnt); end
    finish_prim();
    checks++; if (done !== 1'b1 || blck_cnt !== 2'd3) begin
      errors++; $display("FAIL t6_done: got done=%0b cnt=%0d expected 1/3", done, blck_cnt); end
    tick();
  endtask

  task automatic test_reset_mid_fill();
    op_start(1'b0, 1'b0);
    tick();
    fill_block(1'b0);
    finish_prim();
    tick();
    bb_ready = 1'b1; din_valid = 1'b1; din_eot = 1'b1;
    tick();
    bb_ready = 1'b0; din_valid = 1'b0; din_eot = 1'b0;
    checks++; if (last_blck !== 1'b1 || blck_cnt !== 2'd1) begin
      errors++; $display("FAIL t7_pre: got last=%0b cnt=%0d expected 1/1", last_blck, blck_cnt); end
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || phase !== 2'd3 || last_blck !== 1'b0 || blck_cnt !== 2'd0) begin
      errors++; $display("FAIL t7_async: got busy=%0b phase=%0d last=%0b cnt=%0d expected 0/3/0/0", busy, phase, last_blck, blck_cnt); end
    tick();
    rst = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t7_after: got busy=%0b expected 0", busy); end
  endtask

`ifdef SCHED_ABORT_EN
  task automatic test_abort();
    int dn0;
    dn0 = n_done;
    op_start(1'b0, 1'b1);
    tick();
    fill_block(1'b1);
    tick();
    abort = 1'b1; prim_done = 1'b1;
    tick();
    abort = 1'b0; prim_done = 1'b0;
    checks++; if (busy !== 1'b0 || phase !== 2'd3 || last_blck !== 1'b0 || blck_cnt !== 2'd0) begin
      errors++; $display("FAIL t8_abort: got busy=%0b phase=%0d last=%0b cnt=%0d expected 0/3/0/0", busy, phase, last_blck, blck_cnt); end
    tick();
    checks++; if (n_done != dn0) begin errors++; $display("FAIL t8_no_done: got %0d expected 0", n_done - dn0); end
  endtask
`endif

  initial begin
    test_reset();
    test_ad2_msg1();
    test_both_empty();
    test_msg_only();
    test_blck_rdy_in_arm();
    test_ignored_inputs();
    test_saturation();
    test_reset_mid_fill();
`ifdef SCHED_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
